// File: rtl/div_unit_pkg.sv
// Shared ALU operation codes, divider state encoding and default datapath width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [4:0] ALU_MULT  = 5'd12;
    localparam logic [4:0] ALU_MULTU = 5'd13;
    localparam logic [4:0] ALU_DIV   = 5'd14;
    localparam logic [4:0] ALU_DIVU  = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage: quotient on lo, remainder on hi.
//
// state | meaning
// IDLE  | waiting for a DIV/DIVU start
// ON    | one radix-2 restoring step per cycle, WIDTH cycles
// ZERO  | divisor was zero, result fixed by convention
// DONE  | result valid for one cycle, committed to hi/lo unless flushed
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             flush,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_q, dvs_q, quo, rem, hi_q, lo_q;
    logic             sgn_q;
    logic             is_div, start, commit, neg_quo, neg_rem;
    logic [WIDTH-1:0] dvs_mag, res_quo, res_rem;
    logic [WIDTH:0]   rem_shift, diff;

    assign is_div = (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
    assign start  = en & ~flush & is_div & (state == IDLE);
    assign stall  = resetn & ~flush & (start | (state == ON) | (state == ZERO));
    assign commit = (state == DONE) & ~flush;
    assign done   = commit;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (srcb == '0) ? ZERO : ON;
            ON:      if (cnt == '0) state_nxt = DONE;
            ZERO:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Borrow out of the trial subtraction decides the quotient bit.
    assign dvs_mag   = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_mag};

    assign neg_quo = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
    assign neg_rem = sgn_q & dvd_q[WIDTH-1];

    always_comb begin
        res_quo = neg_quo ? -quo : quo;
        res_rem = neg_rem ? -rem : rem;
        if (dvs_q == '0) begin
            res_quo = '1;
            res_rem = dvd_q;
        end
    end

    assign hi = commit ? res_rem : hi_q;
    assign lo = commit ? res_quo : lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            sgn_q <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                dvd_q <= srca;
                dvs_q <= srcb;
                sgn_q <= (alucontrol == ALU_DIV);
                quo   <= ((alucontrol == ALU_DIV) && srca[WIDTH-1]) ? -srca : srca;
                rem   <= '0;
                cnt   <= CNT_W'(WIDTH - 1);
            end else if (state == ON) begin
                cnt <= cnt - 1'b1;
                if (!diff[WIDTH]) begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= rem_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end
            if (commit) begin
                hi_q <= res_rem;
                lo_q <= res_quo;
            end
        end
    end

endmodule
